mat_row_loader: RTL and testbench

Upstream feeder for the matrix cache. It accepts a load command (target matrix slot, first row, row count), takes a valid/ready stream of `WIDTH`-lane `shortreal` row vectors, and buffers them in a small FIFO. It issues one row write per cycle on the cache write port, unless an external `hold` blocks the port. It sits between the matrix DMA/row stream and the cache write port and owns that port while busy.

---
 rtl/mat_row_loader_pkg.sv | 19 +
 rtl/mat_row_fifo.sv | 60 ++++++
 rtl/mat_row_loader.sv | 148 ++++++++++++++
 tb/tb_mat_row_loader.sv | 419 ++++++++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/mat_row_loader_pkg.sv
// Shared matrix-cache types: write-port opcodes, row element encoding and the
// row loader state enum.
package mat_row_loader_pkg;

    // Each lane carries an IEEE-754 single-precision bit pattern.
    localparam int ELEM_BITS = 32;

    typedef enum logic [1:0] {
        MAT_CACHE_WRITE_NOP = 2'd0,
        MAT_CACHE_WRITE_ROW = 2'd1
    } MatCacheWriteOp_t;

    typedef enum logic [1:0] {
        LOADER_IDLE = 2'd0,
        LOADER_LOAD = 2'd1,
        LOADER_DONE = 2'd2
    } loader_state_t;

endpackage

// File: rtl/mat_row_fifo.sv
// Small synchronous FIFO of row vectors; head is the oldest entry, valid
// whenever empty is low.
module mat_row_fifo
    import mat_row_loader_pkg::*;
#(
    parameter int WIDTH      = 4,
    parameter int FIFO_DEPTH = 2
) (
    input  logic                            clock,
    input  logic                            reset,
    input  logic                            push,
    input  logic                            pop,
    input  logic [WIDTH-1:0][ELEM_BITS-1:0] din,
    output logic                            full,
    output logic                            empty,
    output logic [WIDTH-1:0][ELEM_BITS-1:0] head
);

    localparam int PTR_W = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
    localparam int CNT_W = $clog2(FIFO_DEPTH + 1);

    logic [WIDTH-1:0][ELEM_BITS-1:0] mem [FIFO_DEPTH];
    logic [PTR_W-1:0] rd_ptr;
    logic [PTR_W-1:0] wr_ptr;
    logic [CNT_W-1:0] occupancy;
    logic             push_en;
    logic             pop_en;

    assign full    = (occupancy == CNT_W'(FIFO_DEPTH));
    assign empty   = (occupancy == '0);
    assign push_en = push && !full;
    assign pop_en  = pop && !empty;
    assign head    = mem[rd_ptr];

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            rd_ptr    <= '0;
            wr_ptr    <= '0;
            occupancy <= '0;
        end else begin
            if (push_en)
                wr_ptr <= (wr_ptr == PTR_W'(FIFO_DEPTH - 1)) ? '0 : wr_ptr + 1'b1;
            if (pop_en)
                rd_ptr <= (rd_ptr == PTR_W'(FIFO_DEPTH - 1)) ? '0 : rd_ptr + 1'b1;
            case ({push_en, pop_en})
                2'b10:   occupancy <= occupancy + 1'b1;
                2'b01:   occupancy <= occupancy - 1'b1;
                default: occupancy <= occupancy;
            endcase
        end
    end

    // NOTE: storage is deliberately left out of reset; the pointers define
    // validity, so clearing the array would only cost a reset tree.
    always_ff @(posedge clock) begin
        if (push_en)
            mem[wr_ptr] <= din;
    end

endmodule

// File: rtl/mat_row_loader.sv
// Loads up to WIDTH rows of one matrix slot into the matrix cache, buffering
// the incoming row stream and owning the cache write port while busy.
module mat_row_loader
    import mat_row_loader_pkg::*;
#(
    parameter int WIDTH      = 4,
    parameter int CACHE_SIZE = 4,
    parameter int FIFO_DEPTH = 2
) (
    input  logic                               clock,
    input  logic                               reset,
    input  logic                               cmd_valid,
    output logic                               cmd_ready,
    input  logic [$clog2(CACHE_SIZE)-1:0]      cmd_addr,
    input  logic [$clog2(WIDTH)-1:0]           cmd_first,
    input  logic [$clog2(WIDTH):0]             cmd_count,
    input  logic                               row_valid,
    output logic                               row_ready,
    input  logic [WIDTH-1:0][ELEM_BITS-1:0]    row_data,
    input  logic                               hold,
    output MatCacheWriteOp_t                   write_op,
    output logic [$clog2(CACHE_SIZE)-1:0]      write_addr1,
    output logic [$clog2(WIDTH)-1:0]           write_param,
    output logic [WIDTH-1:0][ELEM_BITS-1:0]    data_in,
    output logic                               busy,
    output logic                               done
);

    localparam int AW = $clog2(CACHE_SIZE);
    localparam int PW = $clog2(WIDTH);
    localparam int CW = PW + 1;

    typedef logic [WIDTH-1:0][ELEM_BITS-1:0] row_t;

    loader_state_t state, state_next;

    logic [AW-1:0] slot_q;
    logic [PW-1:0] first_q;
    logic [PW-1:0] last_param_q;
    logic [CW-1:0] count_q;
    logic [CW-1:0] accepted_q;
    logic [CW-1:0] written_q;
    logic [CW-1:0] count_clamped;
    logic [CW-1:0] row_sum;
    logic [PW-1:0] row_param;
    row_t          fifo_head;
    row_t          last_data_q;
    logic          fifo_full;
    logic          fifo_empty;
    logic          push;
    logic          issue;
    logic          cmd_accept;

    assign count_clamped = (cmd_count > CW'(WIDTH)) ? CW'(WIDTH) : cmd_count;
    assign push          = row_valid && row_ready;
    assign cmd_accept    = cmd_valid && cmd_ready;

    // Row index wraps modulo WIDTH, so a load may start anywhere in the matrix.
    assign row_sum   = {1'b0, first_q} + written_q;
    assign row_param = (row_sum >= CW'(WIDTH)) ? PW'(row_sum - CW'(WIDTH)) : PW'(row_sum);

    mat_row_fifo #(
        .WIDTH      (WIDTH),
        .FIFO_DEPTH (FIFO_DEPTH)
    ) u_fifo (
        .clock (clock),
        .reset (reset),
        .push  (push),
        .pop   (issue),
        .din   (row_data),
        .full  (fifo_full),
        .empty (fifo_empty),
        .head  (fifo_head)
    );

    always_ff @(posedge clock or posedge reset) begin
        if (reset)
            state <= LOADER_IDLE;
        else
            state <= state_next;
    end

    // NOTE: every output of this block gets a default first, so no path
    // through the case statement can leave a signal unassigned (no latches).
    always_comb begin
        state_next = state;
        cmd_ready  = 1'b0;
        row_ready  = 1'b0;
        issue      = 1'b0;
        busy       = 1'b0;
        done       = 1'b0;
        case (state)
            LOADER_IDLE: begin
                cmd_ready = 1'b1;
                if (cmd_valid)
                    state_next = (count_clamped == '0) ? LOADER_DONE : LOADER_LOAD;
            end
            LOADER_LOAD: begin
                busy      = 1'b1;
                row_ready = !fifo_full && (accepted_q < count_q);
                issue     = !fifo_empty && !hold;
                if (issue && (written_q == count_q - CW'(1)))
                    state_next = LOADER_DONE;
            end
            LOADER_DONE: begin
                busy       = 1'b1;
                done       = 1'b1;
                state_next = LOADER_IDLE;
            end
            default: state_next = LOADER_IDLE;
        endcase
    end

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            slot_q       <= '0;
            first_q      <= '0;
            count_q      <= '0;
            accepted_q   <= '0;
            written_q    <= '0;
            last_param_q <= '0;
            last_data_q  <= '0;
        end else begin
            if (cmd_accept) begin
                slot_q     <= cmd_addr;
                first_q    <= cmd_first;
                count_q    <= count_clamped;
                accepted_q <= '0;
                written_q  <= '0;
            end
            if (push)
                accepted_q <= accepted_q + 1'b1;
            if (issue) begin
                written_q    <= written_q + 1'b1;
                last_param_q <= row_param;
                last_data_q  <= fifo_head;
            end
        end
    end

    // Between writes the port shows the last row written, which keeps the
    // cache-side data bus quiet.
    assign write_op    = issue ? MAT_CACHE_WRITE_ROW : MAT_CACHE_WRITE_NOP;
    assign write_addr1 = slot_q;
    assign write_param = issue ? row_param : last_param_q;
    assign data_in     = issue ? fifo_head : last_data_q;

endmodule

// File: tb/tb_mat_row_loader.sv
// Randomised self-checking bench for mat_row_loader; expected writes come from
// a list-level model of which offered rows land in which cache rows.
module tb_mat_row_loader;
    import mat_row_loader_pkg::*;

    localparam int W  = 4;
    localparam int CS = 4;
    localparam int FD = 2;
    localparam int AW = $clog2(CS);
    localparam int PW = $clog2(W);
    localparam int CW = PW + 1;

    typedef logic [W-1:0][31:0] row_t;
    typedef struct {
        logic [AW-1:0] slot;
        logic [PW-1:0] param;
        row_t          data;
        int            cyc;
    } wr_t;

    logic             clock = 1'b0;
    logic             reset;
    logic             cmd_valid;
    logic             cmd_ready;
    logic [AW-1:0]    cmd_addr;
    logic [PW-1:0]    cmd_first;
    logic [CW-1:0]    cmd_count;
    logic             row_valid;
    logic             row_ready;
    row_t             row_data;
    logic             hold;
    MatCacheWriteOp_t write_op;
    logic [AW-1:0]    write_addr1;
    logic [PW-1:0]    write_param;
    row_t             data_in;
    logic             busy;
    logic             done;

    mat_row_loader #(.WIDTH(W), .CACHE_SIZE(CS), .FIFO_DEPTH(FD)) dut (
        .clock       (clock),
        .reset       (reset),
        .cmd_valid   (cmd_valid),
        .cmd_ready   (cmd_ready),
        .cmd_addr    (cmd_addr),
        .cmd_first   (cmd_first),
        .cmd_count   (cmd_count),
        .row_valid   (row_valid),
        .row_ready   (row_ready),
        .row_data    (row_data),
        .hold        (hold),
        .write_op    (write_op),
        .write_addr1 (write_addr1),
        .write_param (write_param),
        .data_in     (data_in),
        .busy        (busy),
        .done        (done)
    );

    always #5 clock = ~clock;

    int   total = 0;
    int   bad   = 0;
    int   cyc   = 0;
    row_t src[$];
    row_t offered[$];
    row_t acc_q[$];
    wr_t  obs_q[$];
    wr_t  exp_q[$];
    int   done_q[$];
    int   cmdacc_q[$];
    bit   offer_en = 1'b1;
    bit   timed_out;
    logic last_row_ready;
    row_t cache_img [CS][W];

    function automatic logic [31:0] f32(int n);
        int p;
        logic [31:0] m;
        if (n == 0) return 32'h0;
        p = 0;
        for (int i = 0; i < 31; i++) if (((n >> i) & 1) == 1) p = i;
        m = 32'(n) << (23 - p);
        return {1'b0, 8'(127 + p), m[22:0]};
    endfunction

    function automatic row_t int_row(int a, int b, int c, int d);
        row_t r;
        r[0] = f32(a); r[1] = f32(b); r[2] = f32(c); r[3] = f32(d);
        return r;
    endfunction

    function automatic row_t rand_row();
        row_t r;
        for (int i = 0; i < W; i++) r[i] = $urandom;
        return r;
    endfunction

    // Model: the k-th offered row lands in cache row (first+k) mod W, for the
    // first min(count, W) rows, all in the commanded slot.
    task automatic build_expected(int slot, int first, int count);
        int  n;
        wr_t e;
        exp_q.delete();
        n = (count > W) ? W : count;
        for (int k = 0; k < n; k++) begin
            e.slot  = AW'(slot);
            e.param = PW'((first + k) % W);
            e.data  = (k < offered.size()) ? offered[k] : '0;
            e.cyc   = 0;
            exp_q.push_back(e);
        end
    endtask

    function automatic int first_diff();
        int n;
        n = (obs_q.size() > exp_q.size()) ? obs_q.size() : exp_q.size();
        for (int k = 0; k < n; k++) begin
            if (k >= obs_q.size() || k >= exp_q.size()) return k;
            if (obs_q[k].slot !== exp_q[k].slot || obs_q[k].param !== exp_q[k].param ||
                obs_q[k].data !== exp_q[k].data) return k;
        end
        return -1;
    endfunction

    task automatic clear_run();
        src.delete(); offered.delete(); acc_q.delete();
        obs_q.delete(); done_q.delete(); cmdacc_q.delete();
    endtask

    task automatic offer(row_t r);
        src.push_back(r);
        offered.push_back(r);
    endtask

    // One clock cycle: drive the row stream, sample mid-cycle, cross the edge.
    task automatic tick();
        bit  took;
        wr_t w;
        if (src.size() > 0 && offer_en) begin
            row_valid = 1'b1;
            row_data  = src[0];
        end else begin
            row_valid = 1'b0;
        end
        #1;
        last_row_ready = row_ready;
        if (write_op == MAT_CACHE_WRITE_ROW) begin
            w.slot = write_addr1; w.param = write_param; w.data = data_in; w.cyc = cyc;
            obs_q.push_back(w);
            cache_img[write_addr1][write_param] = data_in;
        end
        if (done === 1'b1) done_q.push_back(cyc);
        if (cmd_valid && cmd_ready === 1'b1) cmdacc_q.push_back(cyc);
        took = row_valid && (row_ready === 1'b1);
        @(posedge clock);
        #1;
        if (took) acc_q.push_back(src.pop_front());
        cyc++;
    endtask

    task automatic issue_cmd(int slot, int first, int count);
        cmd_valid = 1'b1;
        cmd_addr  = AW'(slot);
        cmd_first = PW'(first);
        cmd_count = CW'(count);
        tick();
        cmd_valid = 1'b0;
    endtask

    task automatic wait_done(int budget, int hold_pct, int offer_pct);
        int start;
        start = done_q.size();
        timed_out = 1'b1;
        for (int i = 0; i < budget; i++) begin
            hold     = ($urandom_range(0, 99) < hold_pct);
            offer_en = ($urandom_range(0, 99) < offer_pct);
            tick();
            if (done_q.size() > start) begin
                timed_out = 1'b0;
                break;
            end
        end
        hold     = 1'b0;
        offer_en = 1'b1;
    endtask

    task automatic test_reset();
        repeat (2) @(posedge clock);
        #1;
        total++; if (cmd_ready !== 1'b1) begin bad++; $display("FAIL reset_cmd_ready: got %b want 1", cmd_ready); end
        total++; if (row_ready !== 1'b0) begin bad++; $display("FAIL reset_row_ready: got %b want 0", row_ready); end
        total++; if (write_op !== MAT_CACHE_WRITE_NOP) begin bad++; $display("FAIL reset_write_op: got %0d want NOP", write_op); end
        total++; if (write_addr1 !== '0 || write_param !== '0) begin bad++; $display("FAIL reset_addr: got slot=%0d row=%0d want 0/0", write_addr1, write_param); end
        total++; if (data_in !== '0) begin bad++; $display("FAIL reset_data: got %h want 0", data_in); end
        total++; if (busy !== 1'b0 || done !== 1'b0) begin bad++; $display("FAIL reset_status: got busy=%b done=%b want 0/0", busy, done); end
        @(negedge clock) reset = 1'b0;
        @(posedge clock);
        #1;
    endtask

    task automatic test_basic();
        int   c0;
        int   d;
        int   diag[4] = '{4, 2, 3, 3};
        row_t last_row;
        clear_run();
        offer(int_row(4, 6, 1, 6));
        offer(int_row(1, 2, 3, 4));
        offer(int_row(3, 3, 3, 3));
        offer(int_row(9, 7, 5, 3));
        last_row = offered[3];
        issue_cmd(2, 0, 4);
        c0 = (cmdacc_q.size() > 0) ? cmdacc_q[0] : -100;
        wait_done(40, 0, 100);
        total++; if (timed_out) begin bad++; $display("FAIL basic_done_timeout: no done within 40 cycles"); end
        build_expected(2, 0, 4);
        d = first_diff();
        total++; if (d != -1) begin bad++; $display("FAIL basic_writes: got %0d writes differing at %0d, want %0d", obs_q.size(), d, exp_q.size()); end
        if (obs_q.size() == 4) begin
            for (int k = 0; k < 4; k++) begin
                total++;
                if (obs_q[k].cyc != c0 + 2 + k) begin bad++; $display("FAIL basic_write_cycle%0d: got %0d want %0d", k, obs_q[k].cyc, c0 + 2 + k); end
            end
            total++;
            if (done_q.size() != 1 || done_q[0] != obs_q[3].cyc + 1) begin
                bad++; $display("FAIL basic_done_cycle: got %0d pulses want one at %0d", done_q.size(), obs_q[3].cyc + 1);
            end
        end
        for (int r = 0; r < 4; r++) begin
            total++;
            if (cache_img[2][r][r] !== f32(diag[r])) begin bad++; $display("FAIL basic_diag%0d: got %h want %h", r, cache_img[2][r][r], f32(diag[r])); end
        end
        tick();
        total++; if (write_param !== PW'(3) || data_in !== last_row) begin bad++; $display("FAIL basic_hold_last: got row=%0d data=%h want 3/%h", write_param, data_in, last_row); end
        total++; if (busy !== 1'b0 || write_op !== MAT_CACHE_WRITE_NOP) begin bad++; $display("FAIL basic_idle: got busy=%b op=%0d want 0/NOP", busy, write_op); end
    endtask

    task automatic test_wrap();
        int slot;
        int d;
        int wrap_exp[3] = '{3, 0, 1};
        clear_run();
        slot = $urandom_range(0, CS - 1);
        for (int k = 0; k < 3; k++) offer(rand_row());
        issue_cmd(slot, 3, 3);
        wait_done(40, 0, 100);
        total++; if (timed_out) begin bad++; $display("FAIL wrap_done_timeout: no done within 40 cycles"); end
        build_expected(slot, 3, 3);
        d = first_diff();
        total++; if (d != -1) begin bad++; $display("FAIL wrap_writes: got %0d writes differing at %0d, want %0d", obs_q.size(), d, exp_q.size()); end
        if (obs_q.size() == 3) begin
            for (int k = 0; k < 3; k++) begin
                total++;
                if (obs_q[k].param !== PW'(wrap_exp[k])) begin bad++; $display("FAIL wrap_row%0d: got %0d want %0d", k, obs_q[k].param, wrap_exp[k]); end
            end
            total++;
            if (done_q.size() != 1 || done_q[0] != obs_q[2].cyc + 1) begin bad++; $display("FAIL wrap_done_cycle: got %0d pulses want one at %0d", done_q.size(), obs_q[2].cyc + 1); end
        end
    endtask

    task automatic test_hold();
        int d;
        int start;
        clear_run();
        for (int k = 0; k < 4; k++) offer(rand_row());
        issue_cmd(1, 0, 4);
        start = done_q.size();
        timed_out = 1'b1;
        for (int i = 0; i < 40; i++) begin
            hold = (i >= 2 && i < 6);
            tick();
            if (i == 3) begin
                total++; if (last_row_ready !== 1'b0) begin bad++; $display("FAIL hold_backpressure: got row_ready=%b want 0", last_row_ready); end
            end
            if (i == 5) begin
                total++; if (obs_q.size() != 1 || acc_q.size() != 3) begin bad++; $display("FAIL hold_stall: got writes=%0d accepted=%0d want 1/3", obs_q.size(), acc_q.size()); end
            end
            if (done_q.size() > start) begin timed_out = 1'b0; break; end
        end
        hold = 1'b0;
        total++; if (timed_out) begin bad++; $display("FAIL hold_done_timeout: no done within 40 cycles"); end
        build_expected(1, 0, 4);
        d = first_diff();
        total++; if (d != -1) begin bad++; $display("FAIL hold_writes: got %0d writes differing at %0d, want %0d", obs_q.size(), d, exp_q.size()); end
    endtask

    task automatic test_count_corners();
        int c0;
        int d;
        clear_run();
        offer(rand_row());
        issue_cmd(1, 2, 0);
        c0 = (cmdacc_q.size() > 0) ? cmdacc_q[0] : -100;
        tick();
        total++; if (done_q.size() != 1 || done_q[0] != c0 + 1) begin bad++; $display("FAIL count0_done: got %0d pulses want one at cycle %0d", done_q.size(), c0 + 1); end
        total++; if (obs_q.size() != 0 || acc_q.size() != 0) begin bad++; $display("FAIL count0_quiet: got writes=%0d accepted=%0d want 0/0", obs_q.size(), acc_q.size()); end
        tick();

        clear_run();
        for (int k = 0; k < 5; k++) offer(rand_row());
        issue_cmd(3, 1, 7);
        wait_done(40, 0, 100);
        total++; if (timed_out) begin bad++; $display("FAIL count7_done_timeout: no done within 40 cycles"); end
        build_expected(3, 1, 7);
        d = first_diff();
        total++; if (d != -1) begin bad++; $display("FAIL count7_writes: got %0d writes differing at %0d, want %0d", obs_q.size(), d, exp_q.size()); end
        tick();
        total++; if (acc_q.size() != 4 || src.size() != 1) begin bad++; $display("FAIL count7_fifth_row: got accepted=%0d left=%0d want 4/1", acc_q.size(), src.size()); end
    endtask

    task automatic test_reset_mid();
        int slot;
        int d;
        clear_run();
        for (int k = 0; k < 4; k++) offer(rand_row());
        issue_cmd(1, 0, 4);
        for (int i = 0; i < 20 && obs_q.size() < 2; i++) tick();
        row_valid = (src.size() > 0);
        if (src.size() > 0) row_data = src[0];
        hold = 1'b0;
        #1;
        total++; if (write_op !== MAT_CACHE_WRITE_ROW) begin bad++; $display("FAIL rstmid_pre_write: got op=%0d want ROW", write_op); end
        #1 reset = 1'b1;
        #1;
        total++; if (write_op !== MAT_CACHE_WRITE_NOP || row_ready !== 1'b0) begin bad++; $display("FAIL rstmid_async: got op=%0d row_ready=%b want NOP/0", write_op, row_ready); end
        total++; if (busy !== 1'b0 || done !== 1'b0 || cmd_ready !== 1'b1) begin bad++; $display("FAIL rstmid_status: got busy=%b done=%b cmd_ready=%b want 0/0/1", busy, done, cmd_ready); end
        total++; if (write_param !== '0 || write_addr1 !== '0 || data_in !== '0) begin bad++; $display("FAIL rstmid_port: got slot=%0d row=%0d data=%h want zeros", write_addr1, write_param, data_in); end
        row_valid = 1'b0;
        @(posedge clock);
        @(negedge clock) reset = 1'b0;
        @(posedge clock);
        #1;
        clear_run();
        repeat (3) tick();
        total++; if (done_q.size() != 0 || busy !== 1'b0 || obs_q.size() != 0) begin bad++; $display("FAIL rstmid_no_done: got done=%0d busy=%b writes=%0d want 0/0/0", done_q.size(), busy, obs_q.size()); end
        slot = $urandom_range(0, CS - 1);
        for (int k = 0; k < 4; k++) offer(rand_row());
        issue_cmd(slot, 1, 4);
        wait_done(40, 20, 80);
        total++; if (timed_out) begin bad++; $display("FAIL rstmid_reload_timeout: no done within 40 cycles"); end
        build_expected(slot, 1, 4);
        d = first_diff();
        total++; if (d != -1) begin bad++; $display("FAIL rstmid_reload: got %0d writes differing at %0d, want %0d", obs_q.size(), d, exp_q.size()); end
    endtask

    task automatic test_cmd_while_busy();
        int d;
        int dn;
        clear_run();
        offer(rand_row());
        offer(rand_row());
        issue_cmd(0, 0, 2);
        cmd_valid = 1'b1;
        cmd_addr  = AW'(3);
        cmd_first = PW'(1);
        cmd_count = CW'(2);
        wait_done(40, 0, 100);
        dn = (done_q.size() > 0) ? done_q[0] : -100;
        tick();
        cmd_valid = 1'b0;
        total++; if (timed_out) begin bad++; $display("FAIL busy_cmd_timeout: no done within 40 cycles"); end
        total++; if (cmdacc_q.size() != 2 || cmdacc_q[1] != dn + 1) begin bad++; $display("FAIL busy_cmd_accept: got %0d accepts want 2, second at %0d", cmdacc_q.size(), dn + 1); end
        build_expected(0, 0, 2);
        d = first_diff();
        total++; if (d != -1) begin bad++; $display("FAIL busy_first_load: got %0d writes differing at %0d, want %0d", obs_q.size(), d, exp_q.size()); end
        obs_q.delete(); offered.delete(); acc_q.delete(); done_q.delete();
        offer(rand_row());
        offer(rand_row());
        wait_done(40, 0, 100);
        build_expected(3, 1, 2);
        d = first_diff();
        total++; if (timed_out || d != -1) begin bad++; $display("FAIL busy_second_load: got %0d writes differing at %0d, want %0d", obs_q.size(), d, exp_q.size()); end
    endtask

    task automatic test_random();
        int slot, first, count, n, c0, d, last;
        for (int it = 0; it < 10; it++) begin
            clear_run();
            slot  = $urandom_range(0, CS - 1);
            first = $urandom_range(0, W - 1);
            count = $urandom_range(0, 7);
            n     = (count > W) ? W : count;
            for (int k = 0; k < W + 1; k++) offer(rand_row());
            issue_cmd(slot, first, count);
            c0 = (cmdacc_q.size() > 0) ? cmdacc_q[0] : -100;
            wait_done(80, 30, 70);
            build_expected(slot, first, count);
            d = first_diff();
            total++; if (timed_out || d != -1) begin bad++; $display("FAIL rand%0d_writes: got %0d writes differing at %0d, want %0d", it, obs_q.size(), d, exp_q.size()); end
            last = (obs_q.size() > 0) ? obs_q[obs_q.size() - 1].cyc : c0;
            total++; if (done_q.size() != 1 || done_q[0] != last + 1) begin bad++; $display("FAIL rand%0d_done: got %0d pulses want one at %0d", it, done_q.size(), last + 1); end
            total++; if (acc_q.size() != n) begin bad++; $display("FAIL rand%0d_accepted: got %0d want %0d", it, acc_q.size(), n); end
        end
    endtask

    initial begin
        reset     = 1'b1;
        cmd_valid = 1'b0;
        cmd_addr  = '0;
        cmd_first = '0;
        cmd_count = '0;
        row_valid = 1'b0;
        row_data  = '0;
        hold      = 1'b0;
        for (int s = 0; s < CS; s++)
            for (int r = 0; r < W; r++) cache_img[s][r] = '0;
        test_reset();
        test_basic();
        test_wrap();
        test_hold();
        test_count_corners();
        test_reset_mid();
        test_cmd_while_busy();
        test_random();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
